// File: rtl/timer_pkg.sv
// Shared types and divider sizing for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Clock edges per tick.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

  // Width of the divider counter.
  function automatic int calc_div_w(input int clk_hz, input int tick_hz);
    return $clog2(clk_hz / tick_hz);
  endfunction

endpackage

// File: rtl/countdown_ctrl_if.sv
// Control/status bundle between the debounced buttons, the timer and the display.
interface countdown_ctrl_if #(parameter int CNT_W = 8) ();
  logic             start;
  logic             pause;
  logic             clear;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] secs;
  logic             running;
  logic             paused;
  logic             expired;
  logic             tick;
  logic             done;

  modport master (
    output start, pause, clear, load_val,
    input  secs, running, paused, expired, tick, done
  );

  modport slave (
    input  start, pause, clear, load_val,
    output secs, running, paused, expired, tick, done
  );
endinterface

// File: rtl/countdown_ctrl_tick_gen.sv
// Seconds divider: counts enabled edges, flags the terminal count.
module tick_gen #(
  parameter int DIV = 10,
  parameter int W   = $clog2(DIV)
) (
  input  logic clk,
  input  logic RESET_N,
  input  logic en,
  input  logic sclr,
  output logic wrap
);

  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  // Synchronous clear wins; otherwise advance and roll over at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (sclr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // Divider count register.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  // Only reachable while running, so it is high for a single RUN edge;
  // the controller qualifies it with state and clear.
  assign wrap = (cnt_q == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Countdown controller: IDLE/RUN/PAUSE/DONE sequencing over a seconds counter,
// producing one-cycle tick/done enables instead of derived clocks.
module countdown_ctrl
  import timer_pkg::*;
#(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             RESET_N,
  countdown_ctrl_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_HZ, TICK_HZ);
  localparam int DIV_W = calc_div_w(CLK_HZ, TICK_HZ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] secs_q, secs_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic at_last;
  logic load_ok;
  logic wrap_edge;
  logic div_en;
  logic div_sclr;

  // A start only loads from IDLE/DONE and only with a non-zero value.
  assign load_ok   = bus.start && (bus.load_val != '0) &&
                     ((state_q == IDLE) || (state_q == DONE));
  assign wrap_edge = (state_q == RUN) && at_last && !bus.clear;
  // A pause freezes the partial second, except on the wrap edge where the
  // tick is still taken and the divider rolls over.
  assign div_en    = (state_q == RUN) && !bus.clear && (!bus.pause || at_last);
  assign div_sclr  = bus.clear || load_ok;

  tick_gen #(.DIV(DIV), .W(DIV_W)) u_tick_gen (
    .clk     (clk),
    .RESET_N (RESET_N),
    .en      (div_en),
    .sclr    (div_sclr),
    .wrap    (at_last)
  );

  // Next state, seconds counter and pulse generation; clear has top priority.
  always_comb begin
    state_d = state_q;
    secs_d  = secs_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    if (bus.clear) begin
      state_d = IDLE;
      secs_d  = '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (load_ok) begin
            state_d = RUN;
            secs_d  = bus.load_val;
          end
        end
        RUN: begin
          if (wrap_edge) begin
            tick_d = 1'b1;
            secs_d = secs_q - 1'b1;
            if (secs_q == CNT_W'(1)) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else if (bus.pause) begin
              state_d = PAUSE;
            end
          end else if (bus.pause) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (bus.start || bus.pause) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, counter and pulse registers.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      secs_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      secs_q  <= secs_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign bus.secs    = secs_q;
  assign bus.running = (state_q == RUN);
  assign bus.paused  = (state_q == PAUSE);
  assign bus.expired = (state_q == DONE);
  assign bus.tick    = tick_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl: directed scenarios plus random pulses, all
// compared every cycle against a second-counting reference model.
module tb_countdown_ctrl;

  localparam int DIV = 10;

  logic clk;
  logic RESET_N;

  countdown_ctrl_if #(.CNT_W(8)) bus ();

  countdown_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8)) dut (
    .clk     (clk),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: mode, seconds left, edges already spent in this second.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_mode, m_secs, m_spent;
  bit m_tick, m_done;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_secs = 0; m_spent = 0; m_tick = 0; m_done = 0;
  endtask

  // One clock edge worth of the timer's rules.
  task automatic model_edge(input bit s, input bit p, input bit c, input int lv);
    m_tick = 0;
    m_done = 0;
    if (c) begin
      m_mode = M_IDLE; m_secs = 0; m_spent = 0;
    end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
      if (s && lv != 0) begin
        m_mode = M_RUN; m_secs = lv; m_spent = 0;
      end
    end else if (m_mode == M_PAUSE) begin
      if (s || p) m_mode = M_RUN;
    end else begin
      // A second completes on its DIV-th running edge.
      if (m_spent + 1 == DIV) begin
        m_spent = 0;
        m_tick  = 1;
        m_secs  = m_secs - 1;
        if (m_secs == 0) begin
          m_mode = M_DONE; m_done = 1;
        end else if (p) begin
          m_mode = M_PAUSE;
        end
      end else if (p) begin
        m_mode = M_PAUSE;
      end else begin
        m_spent = m_spent + 1;
      end
    end
  endtask

  function automatic logic [15:0] dut_vec();
    return {3'b0, bus.secs, bus.running, bus.paused, bus.expired, bus.tick, bus.done};
  endfunction

  function automatic logic [15:0] model_vec();
    return {3'b0, 8'(m_secs), m_mode == M_RUN, m_mode == M_PAUSE, m_mode == M_DONE,
            m_tick, m_done};
  endfunction

  // Apply pulses for one edge, sample #1 later, and compare with the model.
  task automatic cyc(input bit s, input bit p, input bit c);
    int lv;
    bus.start = s; bus.pause = p; bus.clear = c;
    lv = int'(bus.load_val);
    @(posedge clk);
    #1;
    model_edge(s, p, c, lv);
    bus.start = 0; bus.pause = 0; bus.clear = 0;
    chk("cycle", dut_vec(), model_vec());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.load_val = '0;
    RESET_N = 1'b0;
    model_reset();
    #3;
    chk("reset_state", dut_vec(), 16'h0);
    #9 RESET_N = 1'b1;

    // Basic 3-second countdown.
    bus.load_val = 8'd3;
    cyc(1, 0, 0);
    chk("s1_running", {15'b0, bus.running}, 16'd1);
    run(10);
    chk("s1_tick10", {7'b0, bus.secs, bus.tick}, {7'b0, 8'd2, 1'b1});
    run(10);
    chk("s1_tick20", {7'b0, bus.secs, bus.tick}, {7'b0, 8'd1, 1'b1});
    run(10);
    chk("s1_done30", dut_vec(), {3'b0, 8'd0, 5'b00111});
    run(1);
    chk("s1_held", dut_vec(), {3'b0, 8'd0, 5'b00100});

    // Pause preserves the partial second.
    cyc(0, 0, 1);
    bus.load_val = 8'd5;
    cyc(1, 0, 0);
    run(3);
    cyc(0, 1, 0);
    chk("s2_paused4", {15'b0, bus.paused}, 16'd1);
    run(19);
    chk("s2_paused23", {7'b0, bus.secs, bus.paused}, {7'b0, 8'd5, 1'b1});
    cyc(0, 1, 0);
    run(6);
    chk("s2_notick30", {15'b0, bus.tick}, 16'd0);
    run(1);
    chk("s2_tick31", {7'b0, bus.secs, bus.tick}, {7'b0, 8'd4, 1'b1});

    // Ignored starts.
    cyc(0, 0, 1);
    bus.load_val = 8'd0;
    cyc(1, 0, 0);
    chk("s3_zero_load", dut_vec(), 16'h0);
    bus.load_val = 8'd9;
    cyc(1, 0, 0);
    run(4);
    bus.load_val = 8'd2;
    cyc(1, 0, 0);
    chk("s3_no_reload", {8'b0, bus.secs}, 16'd9);
    run(5);
    chk("s3_tick10", {7'b0, bus.secs, bus.tick}, {7'b0, 8'd8, 1'b1});

    // Pause landing on wrap edges.
    cyc(0, 0, 1);
    bus.load_val = 8'd2;
    cyc(1, 0, 0);
    run(9);
    cyc(0, 1, 0);
    chk("s4_wrap_pause", dut_vec(), {3'b0, 8'd1, 5'b01010});
    cyc(0, 1, 0);
    run(9);
    cyc(0, 1, 0);
    chk("s4_wrap_done", dut_vec(), {3'b0, 8'd0, 5'b00111});

    // clear beats a coincident start mid-run.
    cyc(0, 0, 1);
    bus.load_val = 8'd4;
    cyc(1, 0, 0);
    run(5);
    cyc(1, 0, 1);
    chk("s5_clear_start", dut_vec(), 16'h0);
    bus.load_val = 8'd2;
    cyc(1, 0, 0);
    run(9);
    chk("s5_notick9", {15'b0, bus.tick}, 16'd0);
    run(1);
    chk("s5_tick10", {15'b0, bus.tick}, 16'd1);
    run(10);
    chk("s5_tick20_done", {14'b0, bus.tick, bus.done}, 16'd3);

    // Restart from DONE.
    bus.load_val = 8'd1;
    cyc(1, 0, 0);
    chk("s6_restart", {14'b0, bus.expired, bus.running}, 16'd1);
    run(10);
    chk("s6_done", {14'b0, bus.done, bus.expired}, 16'd3);

    // Asynchronous reset mid-run.
    bus.load_val = 8'd3;
    cyc(1, 0, 0);
    run(4);
    RESET_N = 1'b0;
    #2;
    model_reset();
    chk("s7_async_reset", dut_vec(), 16'h0);
    #2 RESET_N = 1'b1;
    run(3);

    // Random pulses against the model.
    for (int i = 0; i < 1500; i++) begin
      bus.load_val = 8'($urandom_range(0, 3));
      cyc($urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
